alu_arb_mux: RTL and testbench
==============================

# alu_arb_mux

Parametrised, registered N-channel operand selector for the simple ALU datapath; the sequential successor to the 4:1 8-bit operand multiplexer. It takes NCH valid/ready input channels of WIDTH bits and forwards one word per transfer through a single output register. Selection is either fixed by a select input or round-robin among requesting channels. It sits between the operand sources and the ALU input register.

## Interface
- WIDTH, 8, data width per channel
- NCH, 4, number of input channels (2..16)
- SELW (localparam), $clog2(NCH), channel index width
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel request
- in_ready  output  NCH  per-channel accept, one-hot or zero
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- out_data  output  WIDTH  registered selected word
- out_ch  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream accepts when high with out_valid
- xfer_cnt  output  16  accepted-output counter (see Configuration)

## Operation
- Reset values: out_data 0, out_ch 0, out_valid 0, in_ready 0, xfer_cnt 0, RR pointer NCH-1, so ch0 has first priority.
- load_en = !out_valid || out_ready. Arbitration happens only when load_en is high.
- Fixed mode: grant = sel when in_valid[sel]. Otherwise there is no grant, and other channels are ignored. sel >= NCH gives no grant.
- RR mode: grant goes to the first valid channel scanning from ptr+1 upward, with modulo-NCH wrap. On a grant, ptr <= grant. In fixed mode ptr is unchanged.
- in_ready[i] = load_en && grant valid && grant == i. This is combinational from in_valid, mode, sel, ptr and out_valid/out_ready. There is no combinational path from in_data.
- Transfer on channel i when in_valid[i] && in_ready[i]: out_data <= word i, out_ch <= i, out_valid <= 1.
- Output drained (out_valid && out_ready) with no new grant: out_valid <= 0. out_data and out_ch hold their last value.
- Drain and load in the same cycle: new word replaces the old one. out_valid stays 1. No bubble.
- Handshake rules: inputs must hold data while valid and not ready. out_data and out_ch are stable while out_valid && !out_ready.
- Mode or sel changes take effect at the next arbitration cycle. A word already in the register is unaffected.
- Reset mid-transfer: the held word is discarded and all state returns to reset values asynchronously.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready is held high.
- RR fairness: with all NCH channels valid and out_ready high, each channel is granted exactly once every NCH consecutive cycles.
- in_ready deasserts in the same cycle that out_valid && !out_ready is true.

## Configuration
- ALU_ARB_MUX_CNT_EN defined: xfer_cnt increments by 1 on every out_valid && out_ready cycle. It wraps 0xFFFF -> 0 and resets to 0.
- Not defined: xfer_cnt is tied to 0 and no counter flops are inferred. The port is present either way.

## Structure
- Shared package alu_pkg: alu_mode_e enum (MODE_FIXED = 1'b0, MODE_RR = 1'b1) and the XFER_CNT_W = 16 constant.
- Sub-module alu_rr_arbiter (NCH): inputs req, ptr; outputs grant index and grant_vld. It is purely combinational. ptr is held in alu_arb_mux.

## Test plan
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_ch and in_ready are all 0 immediately. After release, the first RR grant goes to ch0.
- Fixed mode: mode=0, sel=2, all valid, data {ch0..3}={0x11,0x22,0x33,0x44}, out_ready=1 -> out_data=0x33 and out_ch=2 every cycle. in_ready=4'b0100.
- Fixed mode, selected channel idle: sel=1, in_valid=4'b1101 -> in_ready=0 and out_valid falls to 0 after the drain.
- RR mode: all valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1. Then in_valid=4'b1001 -> grants alternate 3,0 according to ptr.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_ch stable and in_ready=0. On the cycle out_ready rises, the next word loads with no bubble.
- Counter: with ALU_ARB_MUX_CNT_EN, 10 accepted words -> xfer_cnt=10. Preload by forcing 0xFFFF, then one more accept -> 0. Without the macro, xfer_cnt stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand datapath.
package alu_pkg;
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } alu_mode_e;

  localparam int unsigned XFER_CNT_W = 16;
endpackage

// File: rtl/alu_arb_mux_if.sv
// Channel-side and output-side handshake bundle for alu_arb_mux.
interface alu_arb_mux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NCH.
module alu_rr_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] grant,
  output logic                   grant_vld
);
  localparam int unsigned SELW = $clog2(NCH);

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    // Scan farthest-first so the nearest requester after ptr is the last write.
    for (int unsigned k = NCH; k >= 1; k--) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % NCH;
      if (req[idx]) begin
        grant     = SELW'(idx);
        grant_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arb_mux.sv
// Registered N-channel operand selector, fixed-select or round-robin.
// Define ALU_ARB_MUX_CNT_EN to enable the accepted-output counter on xfer_cnt.
module alu_arb_mux
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_arb_mux_if.slave           bus,
  input  logic                   mode,
  input  logic [$clog2(NCH)-1:0] sel,
  output logic [XFER_CNT_W-1:0]  xfer_cnt
);
  localparam int unsigned SELW = $clog2(NCH);

  alu_mode_e        mode_e;
  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  rr_grant;
  logic             rr_vld;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             fix_vld;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  ch_q;
  logic             valid_q;

  assign mode_e = alu_mode_e'(mode);

  alu_rr_arbiter #(.NCH(NCH)) u_rr (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .grant     (rr_grant),
    .grant_vld (rr_vld)
  );

  always_comb begin
    fix_vld = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) fix_vld = bus.in_valid[i];
    end
    if (mode_e == MODE_RR) begin
      grant     = rr_grant;
      grant_vld = rr_vld;
    end else begin
      grant     = sel;
      grant_vld = fix_vld;
    end
    load_en = !valid_q || bus.out_ready;
    // rst_n gating keeps in_ready low for the whole reset assertion.
    xfer    = rst_n && load_en && grant_vld;
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SELW'(NCH - 1);
    end else begin
      if (xfer) begin
        data_q  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
        ch_q    <= grant;
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (xfer && mode_e == MODE_RR) ptr_q <= grant;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

`ifdef ALU_ARB_MUX_CNT_EN
  logic [XFER_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (valid_q && bus.out_ready) begin
      cnt_q <= cnt_q + XFER_CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_arb_mux.sv
// Scoreboard bench for alu_arb_mux: a reference model predicts grants and queues expected words.
module tb_alu_arb_mux;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] xfer_cnt;
  logic [7:0]  din [4];

  item_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  m_ptr;
  logic        m_ov;
  logic [15:0] m_cnt;

  alu_arb_mux_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  alu_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mode     (mode),
    .sel      (sel),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  assign bus.in_data = {din[3], din[2], din[1], din[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef ALU_ARB_MUX_CNT_EN
    return m_cnt;
`else
    return 16'h0;
`endif
  endfunction

  // One clock: drive at negedge, check combinational and registered outputs, advance model.
  task automatic cycle(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
    logic       le, gv;
    logic [1:0] g, g2;
    logic [3:0] er;
    item_t      it;
    mode = m;
    sel = s;
    bus.in_valid = v;
    bus.out_ready = ordy;
    #1;
    le = !m_ov || ordy;
    gv = 1'b0;
    g  = s;
    if (!m) begin
      gv = v[s];
    end else begin
      for (int k = 1; k <= 4; k++) begin
        g2 = m_ptr + 2'(k);
        if (v[g2] && !gv) begin
          g  = g2;
          gv = 1'b1;
        end
      end
    end
    er = (le && gv) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(bus.in_ready), 32'(er));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("xfer_cnt", 32'(xfer_cnt), 32'(cnt_exp()));
    if (m_ov) begin
      it = sb[0];
      check("out_data", 32'(bus.out_data), 32'(it.d));
      check("out_ch", 32'(bus.out_ch), 32'(it.ch));
      if (ordy) begin
        it = sb.pop_front();
        m_cnt++;
      end
    end
    if (le && gv) sb.push_back('{d: din[g], ch: g});
    m_ov = (le && gv) || (m_ov && !ordy);
    if (m && le && gv) m_ptr = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
    mode = 1'b1;
    sel = 2'd0;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b0;
    m_ptr = 2'd3;
    m_ov = 1'b0;
    m_cnt = 16'h0;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_ch", 32'(bus.out_ch), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;

    // Fixed select on ch2, then on an idle ch1
    repeat (5) cycle(1'b0, 2'd2, 4'hF, 1'b1);
    repeat (3) cycle(1'b0, 2'd1, 4'b1101, 1'b1);

    // Round-robin: full rotation, then a sparse pair
    repeat (6) cycle(1'b1, 2'd0, 4'hF, 1'b1);
    repeat (4) cycle(1'b1, 2'd0, 4'b1001, 1'b1);

    // Backpressure then release without a bubble
    cycle(1'b1, 2'd0, 4'hF, 1'b1);
    repeat (3) cycle(1'b1, 2'd0, 4'hF, 1'b0);
    repeat (2) cycle(1'b1, 2'd0, 4'hF, 1'b1);

    // Mixed random traffic
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    repeat (60) cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));

    // Asynchronous reset while a word is held
    cycle(1'b1, 2'd0, 4'hF, 1'b1);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'h0);
    check("mid_rst_out_ch", 32'(bus.out_ch), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    sb.delete();
    m_ov = 1'b0;
    m_ptr = 2'd3;
    m_cnt = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 2'd0, 4'hF, 1'b1);
    check("first_rr_after_rst", 32'(sb[0].ch), 32'h0);
    repeat (10) cycle(1'b1, 2'd0, 4'hF, 1'b1);
    check("cnt_after_10", 32'(xfer_cnt), 32'(cnt_exp()));

`ifdef ALU_ARB_MUX_CNT_EN
    // Counter wrap from a preloaded maximum
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    m_cnt = 16'hFFFF;
    repeat (2) cycle(1'b1, 2'd0, 4'hF, 1'b1);
    check("cnt_wrap", 32'(xfer_cnt), 32'h1);
`endif

    repeat (3) cycle(1'b1, 2'd0, 4'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
